// File: rtl/rx_drain_ctrl_pkg.sv
// ============================================================================
// Module  : rx_drain_ctrl_pkg
// Purpose : Shared types and constants for the receive drain controller.
//           Holds the FSM state encoding, error-flag bit positions inside a
//           FIFO entry's flag field, and the FIFO entry width.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rx_drain_ctrl_pkg;

  // Drain FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STRB = 2'b01,
    WAIT = 2'b10
  } state_e;

  // Bit positions of the error flags within the 3-bit flag field {ov, frm, p}
  localparam int ERR_P   = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_OV  = 2;

  // One FIFO entry: {flags[2:0], data[7:0]}
  localparam int RX_ENTRY_W = 11;

  // Build a FIFO entry from the engine's data byte and error flags.
  function automatic logic [RX_ENTRY_W-1:0] pack_entry(
    input logic       ov,
    input logic       frm,
    input logic       p,
    input logic [7:0] data
  );
    logic [RX_ENTRY_W-1:0] e;
    e              = '0;
    e[7:0]         = data;
    e[8 + ERR_P]   = p;
    e[8 + ERR_FRM] = frm;
    e[8 + ERR_OV]  = ov;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_drain_ctrl_if.sv
// ============================================================================
// Module  : rx_drain_ctrl_if
// Purpose : Bundles the receive-engine side and host side signals of the
//           drain controller.
// Signals : rx_rdy/rx_data/rx_p_err/rx_frm_err/rx_ov_err  engine -> ctrl
//           rx_rd_strb                                     ctrl   -> engine
//           pop/clr_irq                                    host   -> ctrl
//           pop_data/pop_err/empty/full/count/irq/drop_cnt ctrl   -> host
// Modports: master = engine + host side (drives requests)
//           slave  = the drain controller
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface rx_drain_ctrl_if #(
  parameter int AW = 3
);
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_p_err;
  logic          rx_frm_err;
  logic          rx_ov_err;
  logic          rx_rd_strb;
  logic          pop;
  logic [7:0]    pop_data;
  logic [2:0]    pop_err;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          irq;
  logic          clr_irq;
  logic [7:0]    drop_cnt;

  modport master (
    output rx_rdy, rx_data, rx_p_err, rx_frm_err, rx_ov_err, pop, clr_irq,
    input  rx_rd_strb, pop_data, pop_err, empty, full, count, irq, drop_cnt
  );

  modport slave (
    input  rx_rdy, rx_data, rx_p_err, rx_frm_err, rx_ov_err, pop, clr_irq,
    output rx_rd_strb, pop_data, pop_err, empty, full, count, irq, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/rx_drain_ctrl_sync_fifo.sv
// ============================================================================
// Module  : rx_sync_fifo
// Purpose : Single-clock first-word-fall-through FIFO. The head entry is
//           presented combinationally; output reads as zero while empty.
// Ports   : Clk        clock, rising edge
//           Rst        asynchronous active-low reset
//           wr_en_i    write request (ignored when full)
//           wr_data_i  entry to write
//           pop_i      pop request (ignored when empty)
//           rd_data_o  head entry, zero when empty
//           count_o    number of stored entries, 0..DEPTH
//           empty_o    no entries held
//           full_o     DEPTH entries held
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 11
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  rd_data_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = pop_i   & ~empty_o;

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge Clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/rx_drain_ctrl.sv
// ============================================================================
// Module  : rx_drain_ctrl
// Purpose : Drains bytes from the receive engine into a FWFT FIFO, strobes
//           the engine's holding register clear, and presents the host with
//           a pop port, a level interrupt and a saturating overrun counter.
// Ports   : Clk   clock, rising edge
//           Rst   asynchronous active-low reset
//           bus   rx_drain_ctrl_if.slave (engine + host signals)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_drain_ctrl
  import rx_drain_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int THRESH = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  rx_drain_ctrl_if.slave bus
);

  state_e                state_q, state_d;
  logic                  wr_en;
  logic [RX_ENTRY_W-1:0] wr_entry;
  logic [RX_ENTRY_W-1:0] rd_entry;
  logic [AW:0]           fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  wr_any_err;
  logic                  err_irq_q, err_irq_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  thr_irq;

  assign wr_entry   = pack_entry(bus.rx_ov_err, bus.rx_frm_err, bus.rx_p_err, bus.rx_data);
  assign wr_any_err = bus.rx_p_err | bus.rx_frm_err | bus.rx_ov_err;

  // ------------------------------------------------------------------------
  // Drain FSM. The write is taken on the IDLE edge; the strobe follows as a
  // Moore output, and WAIT blocks re-capture until the engine drops rx_rdy
  // so a slow-to-clear Rx_rdy cannot be read twice.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_rdy && !fifo_full) begin
          wr_en   = 1'b1;
          state_d = STRB;
        end
      end
      STRB: state_d = WAIT;
      WAIT: begin
        if (!bus.rx_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign bus.rx_rd_strb = (state_q == STRB);

  // ------------------------------------------------------------------------
  // Entry storage
  // ------------------------------------------------------------------------
  rx_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (RX_ENTRY_W)
  ) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_entry),
    .pop_i     (bus.pop),
    .rd_data_o (rd_entry),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign bus.pop_data = rd_entry[7:0];
  assign bus.pop_err  = rd_entry[8 +: 3];
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.count    = fifo_count;

  // ------------------------------------------------------------------------
  // Interrupts: sticky error flag where a new error beats a same-cycle clear.
  // ------------------------------------------------------------------------
  always_comb begin
    err_irq_d = err_irq_q;
    if (wr_en && wr_any_err) err_irq_d = 1'b1;
    else if (bus.clr_irq)    err_irq_d = 1'b0;
  end

  assign thr_irq = (fifo_count >= (AW+1)'(THRESH));
  assign bus.irq = thr_irq | err_irq_q;

  // ------------------------------------------------------------------------
  // Overrun counter, saturating at 255
  // ------------------------------------------------------------------------
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wr_en && bus.rx_ov_err && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      err_irq_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      err_irq_q  <= err_irq_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_drain_ctrl.sv
// ============================================================================
// Module  : tb_rx_drain_ctrl
// Purpose : Self-checking bench for rx_drain_ctrl. A queue-based model
//           predicts every output each cycle; directed scenarios add literal
//           expectations.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_drain_ctrl;

  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int THRESH = 4;

  logic Clk;
  logic Rst;

  rx_drain_ctrl_if #(.AW(AW)) bus ();

  rx_drain_ctrl #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .THRESH (THRESH)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int strb_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: the FIFO is a queue of {ov,frm,p,data}. A byte is taken when the
  // controller is ready, rx_rdy is high and the queue has room. After a
  // take, the controller is ready again only once rx_rdy is seen low on an
  // edge at least two edges after the take.
  // --------------------------------------------------------------------------
  logic [10:0] mq[$];
  logic [10:0] m_dummy;
  bit          m_ready;
  int          m_wait;
  bit          m_strb;
  bit          m_err;
  int          m_drop;
  bit          m_cap;
  bit          m_pop;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mq.delete();
      m_ready = 1'b1;
      m_wait  = 0;
      m_strb  = 1'b0;
      m_err   = 1'b0;
      m_drop  = 0;
    end else begin
      m_cap = m_ready && bus.rx_rdy && (mq.size() < DEPTH);
      m_pop = bus.pop && (mq.size() > 0);
      if (m_pop) m_dummy = mq.pop_front();
      if (m_cap) mq.push_back({bus.rx_ov_err, bus.rx_frm_err, bus.rx_p_err, bus.rx_data});
      if (m_cap && (bus.rx_ov_err || bus.rx_frm_err || bus.rx_p_err)) m_err = 1'b1;
      else if (bus.clr_irq) m_err = 1'b0;
      if (m_cap && bus.rx_ov_err && m_drop < 255) m_drop++;
      if (m_cap) begin
        m_ready = 1'b0;
        m_wait  = 0;
      end else if (!m_ready) begin
        if (m_wait >= 1 && !bus.rx_rdy) m_ready = 1'b1;
        m_wait++;
      end
      m_strb = m_cap;
    end
  end

  // Compare process: one settle step after every rising edge.
  always @(posedge Clk) begin
    #1;
    if (bus.rx_rd_strb === 1'b1) strb_cnt++;
    if (Rst && chk_en) begin
      check("strb",     bus.rx_rd_strb, m_strb);
      check("count",    bus.count, mq.size());
      check("empty",    bus.empty, mq.size() == 0);
      check("full",     bus.full, mq.size() == DEPTH);
      check("pop_data", bus.pop_data, (mq.size() == 0) ? 0 : mq[0][7:0]);
      check("pop_err",  bus.pop_err, (mq.size() == 0) ? 0 : mq[0][10:8]);
      check("irq",      bus.irq, (mq.size() >= THRESH) || m_err);
      check("drop_cnt", bus.drop_cnt, m_drop);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] d);
    bit seen;
    seen = 1'b0;
    bus.rx_data = d;
    bus.rx_rdy  = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clk);
      if (bus.rx_rd_strb === 1'b1) seen = 1'b1;
    end
    bus.rx_rdy = 1'b0;
    check("strobe_timeout", seen, 1);
    repeat (2) @(negedge Clk);
  endtask

  task automatic pop_one();
    bus.pop = 1'b1;
    @(negedge Clk);
    bus.pop = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int s0;

  initial begin
    bus.rx_rdy = 0; bus.rx_data = 0; bus.rx_p_err = 0; bus.rx_frm_err = 0;
    bus.rx_ov_err = 0; bus.pop = 0; bus.clr_irq = 0;
    Rst = 1'b0;
    repeat (3) @(negedge Clk);

    // Reset state
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full",  bus.full, 0);
    check("rst_strb",  bus.rx_rd_strb, 0);
    check("rst_irq",   bus.irq, 0);
    check("rst_drop",  bus.drop_cnt, 0);
    check("rst_pdata", bus.pop_data, 0);

    Rst = 1'b1;
    chk_en = 1'b1;
    @(negedge Clk);

    // Single byte: captured on the first edge, strobe in the next cycle
    bus.rx_data = 8'hA5;
    bus.rx_rdy  = 1'b1;
    @(negedge Clk);
    check("single_strb",  bus.rx_rd_strb, 1);
    check("single_count", bus.count, 1);
    check("single_data",  bus.pop_data, 8'hA5);
    check("single_err",   bus.pop_err, 0);
    check("single_irq",   bus.irq, 0);
    bus.rx_rdy = 1'b0;
    @(negedge Clk);
    check("single_strb_off", bus.rx_rd_strb, 0);
    pop_one();
    repeat (2) @(negedge Clk);

    // Stale rx_rdy held high: exactly one capture
    s0 = strb_cnt;
    bus.rx_data = 8'h3C;
    bus.rx_rdy  = 1'b1;
    repeat (11) @(negedge Clk);
    check("hold_count", bus.count, 1);
    check("hold_strobes", strb_cnt - s0, 1);
    bus.rx_rdy = 1'b0;
    repeat (2) @(negedge Clk);
    pop_one();
    repeat (2) @(negedge Clk);

    // Threshold interrupt
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i));
      if (i == 3) check("thr_irq_below", bus.irq, 0);
      if (i == 4) check("thr_irq_at",    bus.irq, 1);
    end
    for (int i = 1; i <= 4; i++) begin
      check("thr_pop_order", bus.pop_data, i);
      pop_one();
    end
    check("thr_empty", bus.empty, 1);
    check("thr_irq_off", bus.irq, 0);

    // Full backpressure
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    check("full_flag", bus.full, 1);
    check("full_count", bus.count, 8);
    s0 = strb_cnt;
    bus.rx_data = 8'h99;
    bus.rx_rdy  = 1'b1;
    repeat (5) @(negedge Clk);
    check("full_no_strobe", strb_cnt - s0, 0);
    pop_one();
    check("full_after_pop", bus.count, 7);
    @(negedge Clk);
    check("full_refill", bus.count, 8);
    check("full_resume_strb", bus.rx_rd_strb, 1);
    bus.rx_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("full_head", bus.pop_data, 8'h11);
      if (i == 7) check("full_tail", bus.pop_data, 8'h99);
      pop_one();
    end
    check("full_drained", bus.empty, 1);
    repeat (2) @(negedge Clk);

    // Framing error written in the same cycle as clr_irq: set wins
    bus.rx_data    = 8'h5A;
    bus.rx_frm_err = 1'b1;
    bus.clr_irq    = 1'b1;
    bus.rx_rdy     = 1'b1;
    @(negedge Clk);
    bus.clr_irq    = 1'b0;
    bus.rx_rdy     = 1'b0;
    bus.rx_frm_err = 1'b0;
    check("frm_irq_set", bus.irq, 1);
    check("frm_pop_err", bus.pop_err, 3'b010);
    repeat (2) @(negedge Clk);
    check("frm_irq_sticky", bus.irq, 1);
    bus.clr_irq = 1'b1;
    @(negedge Clk);
    bus.clr_irq = 1'b0;
    check("frm_irq_cleared", bus.irq, 0);
    pop_one();
    repeat (2) @(negedge Clk);

    // Overrun counter saturation with continuous popping
    bus.pop       = 1'b1;
    bus.rx_ov_err = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'(i));
      if (i == 9) check("drop_at_10", bus.drop_cnt, 10);
    end
    bus.rx_ov_err = 1'b0;
    check("drop_sat", bus.drop_cnt, 255);
    repeat (2) @(negedge Clk);
    bus.pop = 1'b0;
    check("ov_empty", bus.empty, 1);

    // Reset asserted while the strobe is high
    bus.rx_data = 8'hEE;
    bus.rx_rdy  = 1'b1;
    @(posedge Clk);
    #3;
    check("pre_rst_strb", bus.rx_rd_strb, 1);
    Rst = 1'b0;
    #1;
    check("mid_rst_strb",  bus.rx_rd_strb, 0);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_drop",  bus.drop_cnt, 0);
    check("mid_rst_empty", bus.empty, 1);
    bus.rx_rdy = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("post_rst_count", bus.count, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_drain_ctrl.md
Name: rx_drain_ctrl

Overview:
- Receive-side controller that sits between the RxEngine status/data outputs and the host register interface.
- Watches Rx_rdy and captures the received byte plus its error flags into a small FIFO.
- Issues the one-cycle read strobe that clears the engine's holding register.
- Gives the host a first-word-fall-through pop port, a level interrupt and a saturating overrun counter.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of two, minimum 2.
AW, 3, pointer width; AW = log2(DEPTH).
THRESH, 4, fill level (1..DEPTH) at which the threshold interrupt asserts.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-low reset.
rx_rdy  in  1  Rx_rdy from the receive engine; high while a byte is held.
rx_data  in  8  Rx_out from the receive engine.
rx_p_err  in  1  parity error flag from the engine.
rx_frm_err  in  1  framing error flag from the engine.
rx_ov_err  in  1  overflow error flag from the engine.
rx_rd_strb  out  1  read strobe to the engine; pulses for one cycle per captured byte.
pop  in  1  host pop request; ignored when empty.
pop_data  out  8  data of the head entry; valid while empty=0.
pop_err  out  3  error flags of the head entry, ordered {ov, frm, p}.
empty  out  1  FIFO holds no entries.
full  out  1  FIFO holds DEPTH entries.
count  out  AW+1  current number of entries, 0..DEPTH.
irq  out  1  interrupt = thr_irq OR err_irq.
clr_irq  in  1  clears the sticky err_irq.
drop_cnt  out  8  saturating count of entries written with ov=1.

Behaviour:
- Reset (Rst=0, asynchronous) values:
  - state=IDLE; rd_ptr=wr_ptr=0; count=0; empty=1; full=0.
  - rx_rd_strb=0; err_irq=0; irq=0; drop_cnt=0.
  - pop_data=0 and pop_err=0 while empty.
- FSM states are IDLE, STRB and WAIT. Outputs are Moore.
  - IDLE: if rx_rdy=1 and full=0 at a clock edge, write {ov,frm,p,data} into the FIFO and go to STRB. If full=1, stay in IDLE with no strobe; this is backpressure, and the engine flags ov_err on its next byte.
  - STRB: rx_rd_strb=1 for exactly this cycle, then go to WAIT.
  - WAIT: stay until rx_rdy=0, then go to IDLE. This prevents a stale Rx_rdy from causing a double capture.
- Latency: the byte is written on the first edge with IDLE & rx_rdy & ~full. rx_rd_strb is high in the following cycle. The earliest next capture is 3 cycles later.
- FIFO:
  - First-word-fall-through: pop_data/pop_err reflect entry[rd_ptr].
  - A pop with empty=0 advances rd_ptr at the edge.
  - Pointers wrap modulo DEPTH.
  - count is incremented or decremented per edge.
  - Simultaneous write and pop: both pointers advance and count is unchanged. This is allowed even when full=1 only if the write was already qualified; because a write requires ~full, a full FIFO plus pop gives count-1.
  - Pop while empty: no pointer change and no underflow.
- thr_irq is combinational: count >= THRESH.
- err_irq:
  - Set on any write whose p, frm or ov flag is 1.
  - Cleared by clr_irq.
  - If set and clear occur in the same cycle, set wins.
- drop_cnt increments on a write with ov=1 and saturates at 255. It is cleared only by reset.
- Reset mid-operation (including in STRB) drops rx_rd_strb immediately and discards FIFO contents.

Decomposition:
- Shared package/include holds:
  - the FSM state encodings (IDLE=2'b00, STRB=2'b01, WAIT=2'b10);
  - error-bit index constants ERR_P=0, ERR_FRM=1, ERR_OV=2;
  - the entry width constant RX_ENTRY_W=11.
- One sub-module: rx_sync_fifo, parameterised on DEPTH/AW/width, providing write, pop, count, empty and full.
- The FSM, interrupt logic and drop counter stay in rx_drain_ctrl.

Test Plan:
- Single byte: rx_data=8'hA5, rx_rdy pulse held until strobe. Required: rx_rd_strb high exactly 1 cycle, 1 cycle after capture; count=1; pop_data=A5; pop_err=0; irq=0.
- Hold rx_rdy high for 10 cycles after the strobe. Required: exactly one write; count stays 1; no second strobe.
- Fill to THRESH (4 bytes 8'h01..8'h04). Required: irq rises on the 4th write. Four pops return 01,02,03,04 in order, then empty=1 and irq=0.
- Fill 8 entries with rx_rdy still high. Required: full=1, no strobe. Pop once: capture resumes next cycle and count returns to 8.
- Byte with rx_frm_err=1 and clr_irq asserted in the same cycle as the write. Required: err_irq=1 and pop_err=3'b010. A later clr_irq alone clears it.
- 300 writes with rx_ov_err=1 (popping continuously). Required: drop_cnt saturates at 255. Assert Rst during STRB: rx_rd_strb=0 immediately, count=0, drop_cnt=0.
